// File: rtl/mpi_ring_scheduler.sv
// Ring all-reduce step scheduler: walks reduce-scatter then all-gather over N-1 steps each,
// issuing one tx and one rx chunk command per step and waiting for both datapath completions.
module mpi_ring_scheduler #(
   parameter int unsigned MAX_CLIENT = 8
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start,
   input  logic [31:0] client_id,
   input  logic [31:0] client_num,
   input  logic [31:0] client_length,
   input  logic [63:0] base_addr,
   output logic        send_cmd_valid,
   input  logic        send_cmd_ready,
   output logic [7:0]  send_cmd_chunk,
   output logic [63:0] send_cmd_addr,
   output logic [31:0] send_cmd_len,
   output logic        recv_cmd_valid,
   input  logic        recv_cmd_ready,
   output logic [7:0]  recv_cmd_chunk,
   output logic [63:0] recv_cmd_addr,
   output logic        recv_cmd_reduce,
   input  logic        send_done,
   input  logic        recv_done,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic        phase,
   output logic [7:0]  step
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CHECK  = 3'd1;
   localparam logic [2:0] S_ISSUE  = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_NEXT   = 3'd4;
   localparam logic [2:0] S_FINISH = 3'd5;

   logic [2:0]  r_state;
   logic [31:0] r_id;
   logic [31:0] r_num;
   logic [31:0] r_len;
   logic [63:0] r_base;
   logic [7:0]  r_send_chunk;
   logic [7:0]  r_recv_chunk;
   logic [7:0]  r_step;
   logic        r_phase;
   logic        r_send_acc;
   logic        r_recv_acc;
   logic        r_send_flag;
   logic        r_recv_flag;
   logic        r_error;

   logic [7:0]  w_n8;
   logic        w_invalid;
   logic        w_send_fire;
   logic        w_recv_fire;
   logic        w_send_acc;
   logic        w_recv_acc;
   logic        w_track;
   logic        w_send_flag;
   logic        w_recv_flag;
   logic        w_phase_end;
   logic        w_last;
   logic [7:0]  w_send_dec;
   logic [7:0]  w_recv_dec;
   logic [7:0]  w_id_prev;

   assign w_n8      = r_num[7:0];
   assign w_invalid = (r_num < 32'd2) | (r_num > MAX_CLIENT) | (r_id >= r_num)
                    | (r_len == 32'd0);

   assign send_cmd_valid = (r_state == S_ISSUE) & ~r_send_acc;
   assign recv_cmd_valid = (r_state == S_ISSUE) & ~r_recv_acc;
   assign w_send_fire    = send_cmd_valid & send_cmd_ready;
   assign w_recv_fire    = recv_cmd_valid & recv_cmd_ready;
   assign w_send_acc     = r_send_acc | w_send_fire;
   assign w_recv_acc     = r_recv_acc | w_recv_fire;

   // Completion pulses only count once their own command has been taken this step
   assign w_track     = (r_state == S_ISSUE) | (r_state == S_WAIT);
   assign w_send_flag = r_send_flag | (w_track & send_done & w_send_acc);
   assign w_recv_flag = r_recv_flag | (w_track & recv_done & w_recv_acc);

   assign w_phase_end = (r_step == (w_n8 - 8'd2));
   assign w_last      = r_phase & w_phase_end;
   assign w_send_dec  = (r_send_chunk == 8'd0) ? (w_n8 - 8'd1) : (r_send_chunk - 8'd1);
   assign w_recv_dec  = (r_recv_chunk == 8'd0) ? (w_n8 - 8'd1) : (r_recv_chunk - 8'd1);
   assign w_id_prev   = (r_id[7:0] == 8'd0) ? (w_n8 - 8'd1) : (r_id[7:0] - 8'd1);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= S_IDLE;
         r_id         <= '0;
         r_num        <= '0;
         r_len        <= '0;
         r_base       <= '0;
         r_send_chunk <= '0;
         r_recv_chunk <= '0;
         r_step       <= '0;
         r_phase      <= 1'b0;
         r_send_acc   <= 1'b0;
         r_recv_acc   <= 1'b0;
         r_send_flag  <= 1'b0;
         r_recv_flag  <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_id    <= client_id;
                  r_num   <= client_num;
                  r_len   <= client_length;
                  r_base  <= base_addr;
                  r_error <= 1'b0;
                  r_state <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (w_invalid) begin
                  r_error <= 1'b1;
                  r_state <= S_FINISH;
               end else begin
                  r_step       <= '0;
                  r_phase      <= 1'b0;
                  r_send_chunk <= r_id[7:0];
                  r_recv_chunk <= w_id_prev;
                  r_send_acc   <= 1'b0;
                  r_recv_acc   <= 1'b0;
                  r_send_flag  <= 1'b0;
                  r_recv_flag  <= 1'b0;
                  r_state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_send_acc  <= w_send_acc;
               r_recv_acc  <= w_recv_acc;
               r_send_flag <= w_send_flag;
               r_recv_flag <= w_recv_flag;
               if (w_send_acc && w_recv_acc) begin
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               r_send_flag <= w_send_flag;
               r_recv_flag <= w_recv_flag;
               if (w_send_flag && w_recv_flag) begin
                  r_state <= S_NEXT;
               end
            end
            S_NEXT: begin
               r_send_acc  <= 1'b0;
               r_recv_acc  <= 1'b0;
               r_send_flag <= 1'b0;
               r_recv_flag <= 1'b0;
               if (w_last) begin
                  r_state <= S_FINISH;
               end else begin
                  r_send_chunk <= w_send_dec;
                  r_recv_chunk <= w_recv_dec;
                  if (w_phase_end) begin
                     r_phase <= 1'b1;
                     r_step  <= '0;
                  end else begin
                     r_step  <= r_step + 8'd1;
                  end
                  r_state <= S_ISSUE;
               end
            end
            S_FINISH: r_state <= S_IDLE;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

   assign busy            = (r_state != S_IDLE);
   assign done            = (r_state == S_FINISH);
   assign error           = r_error;
   assign phase           = r_phase;
   assign step            = r_step;
   assign send_cmd_chunk  = r_send_chunk;
   assign recv_cmd_chunk  = r_recv_chunk;
   assign send_cmd_addr   = r_base + 64'(r_send_chunk) * 64'(r_len);
   assign recv_cmd_addr   = r_base + 64'(r_recv_chunk) * 64'(r_len);
   assign send_cmd_len    = r_len;
   // Gated by busy so the reset/idle value is 0 rather than ~phase
   assign recv_cmd_reduce = ~r_phase & busy;

endmodule

// File: tb/tb_mpi_ring_scheduler.sv
// Directed bench for mpi_ring_scheduler: ring sequence, invalid configs, backpressure,
// done-pulse qualification, ignored restart and asynchronous reset mid-run.
module tb_mpi_ring_scheduler;

   logic        clk = 1'b0;
   logic        rstn;
   logic        start;
   logic [31:0] client_id, client_num, client_length;
   logic [63:0] base_addr;
   logic        send_cmd_valid, send_cmd_ready, recv_cmd_valid, recv_cmd_ready;
   logic [7:0]  send_cmd_chunk, recv_cmd_chunk, step;
   logic [63:0] send_cmd_addr, recv_cmd_addr;
   logic [31:0] send_cmd_len;
   logic        recv_cmd_reduce, send_done, recv_done, busy, done, error, phase;

   logic        auto_en, auto_send_done, auto_recv_done, man_send_done, man_recv_done;
   int          s_cnt, r_cnt;
   int          n_checks, n_fail;
   int          done_cnt, busy_cnt, valid_cnt;
   logic [7:0]  q_s_chunk[$], q_r_chunk[$], q_step[$];
   logic        q_reduce[$], q_phase[$];
   logic [63:0] q_s_addr[$], q_r_addr[$];

   always #5 clk = ~clk;

   assign send_done = auto_send_done | man_send_done;
   assign recv_done = auto_recv_done | man_recv_done;

   mpi_ring_scheduler #(.MAX_CLIENT(8)) dut (
      .clk(clk), .rstn(rstn), .start(start),
      .client_id(client_id), .client_num(client_num), .client_length(client_length),
      .base_addr(base_addr),
      .send_cmd_valid(send_cmd_valid), .send_cmd_ready(send_cmd_ready),
      .send_cmd_chunk(send_cmd_chunk), .send_cmd_addr(send_cmd_addr),
      .send_cmd_len(send_cmd_len),
      .recv_cmd_valid(recv_cmd_valid), .recv_cmd_ready(recv_cmd_ready),
      .recv_cmd_chunk(recv_cmd_chunk), .recv_cmd_addr(recv_cmd_addr),
      .recv_cmd_reduce(recv_cmd_reduce),
      .send_done(send_done), .recv_done(recv_done),
      .busy(busy), .done(done), .error(error), .phase(phase), .step(step)
   );

   // Datapath model: one done pulse 3 cycles after each accepted command
   always @(negedge clk) begin
      #2;
      auto_send_done = 1'b0;
      auto_recv_done = 1'b0;
      if (!rstn || !auto_en) begin
         s_cnt = 0;
         r_cnt = 0;
      end else begin
         if (s_cnt > 0) begin
            s_cnt--;
            if (s_cnt == 0) auto_send_done = 1'b1;
         end
         if (r_cnt > 0) begin
            r_cnt--;
            if (r_cnt == 0) auto_recv_done = 1'b1;
         end
         if (send_cmd_valid && send_cmd_ready) s_cnt = 3;
         if (recv_cmd_valid && recv_cmd_ready) r_cnt = 3;
      end
   end

   always @(negedge clk) begin
      #2;
      if (send_cmd_valid && send_cmd_ready) begin
         q_s_chunk.push_back(send_cmd_chunk);
         q_s_addr.push_back(send_cmd_addr);
         q_step.push_back(step);
         q_phase.push_back(phase);
      end
      if (recv_cmd_valid && recv_cmd_ready) begin
         q_r_chunk.push_back(recv_cmd_chunk);
         q_r_addr.push_back(recv_cmd_addr);
         q_reduce.push_back(recv_cmd_reduce);
      end
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      if (send_cmd_valid || recv_cmd_valid) valid_cnt++;
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      done_cnt = 0; busy_cnt = 0; valid_cnt = 0;
      q_s_chunk.delete(); q_r_chunk.delete(); q_step.delete();
      q_reduce.delete(); q_phase.delete(); q_s_addr.delete(); q_r_addr.delete();
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_busy"}, 64'(busy), 64'd0);
      check_val({tag, "_done"}, 64'(done), 64'd0);
      check_val({tag, "_error"}, 64'(error), 64'd0);
      check_val({tag, "_svalid"}, 64'(send_cmd_valid), 64'd0);
      check_val({tag, "_rvalid"}, 64'(recv_cmd_valid), 64'd0);
      check_val({tag, "_step"}, 64'(step), 64'd0);
      check_val({tag, "_phase"}, 64'(phase), 64'd0);
      check_val({tag, "_schunk"}, 64'(send_cmd_chunk), 64'd0);
      check_val({tag, "_rchunk"}, 64'(recv_cmd_chunk), 64'd0);
      check_val({tag, "_saddr"}, send_cmd_addr, 64'd0);
      check_val({tag, "_raddr"}, recv_cmd_addr, 64'd0);
      check_val({tag, "_len"}, 64'(send_cmd_len), 64'd0);
      check_val({tag, "_reduce"}, 64'(recv_cmd_reduce), 64'd0);
   endtask

   task automatic set_cfg(input logic [31:0] id, input logic [31:0] num);
      client_id = id; client_num = num;
      client_length = 32'h1000; base_addr = 64'h1_0000_0000;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done_cnt != 0) break;
      end
      repeat (2) @(negedge clk);
      check_val({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
      check_val({tag, "_error_end"}, 64'(error), 64'd0);
      check_val({tag, "_busy_end"}, 64'(busy), 64'd0);
   endtask

   task automatic run_full(input bit mid_start, input string tag);
      logic [7:0] exp_s[6] = '{8'd1, 8'd0, 8'd3, 8'd2, 8'd1, 8'd0};
      logic [7:0] exp_r[6] = '{8'd0, 8'd3, 8'd2, 8'd1, 8'd0, 8'd3};
      logic [7:0] exp_st[6] = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2};
      logic       exp_red[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      clear_mon();
      set_cfg(32'd1, 32'd4);
      send_cmd_ready = 1'b1; recv_cmd_ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_val({tag, "_valid_t1"}, 64'(send_cmd_valid), 64'd0);
      check_val({tag, "_err_clr"}, 64'(error), 64'd0);
      @(negedge clk);
      check_val({tag, "_valid_t2"}, 64'(send_cmd_valid & recv_cmd_valid), 64'd1);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (mid_start && i == 10) begin
            start = 1'b1; client_id = 32'd2; client_num = 32'd3;
         end else begin
            start = 1'b0; client_id = 32'd1; client_num = 32'd4;
         end
         if (done_cnt != 0) break;
      end
      start = 1'b0; client_id = 32'd1; client_num = 32'd4;
      repeat (2) @(negedge clk);
      check_val({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
      check_val({tag, "_error_end"}, 64'(error), 64'd0);
      check_val({tag, "_busy_end"}, 64'(busy), 64'd0);
      check_val({tag, "_n_send"}, 64'(q_s_chunk.size()), 64'd6);
      check_val({tag, "_n_recv"}, 64'(q_r_chunk.size()), 64'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < q_s_chunk.size()) begin
            check_val($sformatf("%s_schunk%0d", tag, i), 64'(q_s_chunk[i]), 64'(exp_s[i]));
            check_val($sformatf("%s_step%0d", tag, i), 64'(q_step[i]), 64'(exp_st[i]));
            check_val($sformatf("%s_phase%0d", tag, i), 64'(q_phase[i]), 64'(i >= 3));
         end
         if (i < q_r_chunk.size()) begin
            check_val($sformatf("%s_rchunk%0d", tag, i), 64'(q_r_chunk[i]), 64'(exp_r[i]));
            check_val($sformatf("%s_reduce%0d", tag, i), 64'(q_reduce[i]), 64'(exp_red[i]));
         end
      end
      if (q_s_addr.size() > 0)
         check_val({tag, "_saddr0"}, q_s_addr[0], 64'h1_0000_1000);
      if (q_r_addr.size() > 0)
         check_val({tag, "_raddr0"}, q_r_addr[0], 64'h1_0000_0000);
   endtask

   task automatic run_invalid(input string tag, input logic [31:0] id, input logic [31:0] num);
      clear_mon();
      set_cfg(id, num);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      check_val({tag, "_valids"}, 64'(valid_cnt), 64'd0);
      check_val({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
      check_val({tag, "_busy_cyc"}, 64'(busy_cnt), 64'd2);
      check_val({tag, "_error"}, 64'(error), 64'd1);
      check_val({tag, "_busy_end"}, 64'(busy), 64'd0);
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      auto_en = 1'b1; man_send_done = 1'b0; man_recv_done = 1'b0;
      auto_send_done = 1'b0; auto_recv_done = 1'b0;
      start = 1'b0; send_cmd_ready = 1'b1; recv_cmd_ready = 1'b1;
      set_cfg(32'd1, 32'd4);
      clear_mon();
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      run_invalid("num1", 32'd0, 32'd1);
      run_invalid("id5", 32'd5, 32'd4);
      check_val("err_hold", 64'(error), 64'd1);

      run_full(1'b0, "ring");
      run_full(1'b1, "restart");

      // Send backpressured for 5 cycles while recv is accepted at once
      clear_mon();
      set_cfg(32'd1, 32'd4);
      send_cmd_ready = 1'b0; recv_cmd_ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check_val("bp_rvalid0", 64'(recv_cmd_valid), 64'd1);
      for (int j = 0; j < 5; j++) begin
         check_val($sformatf("bp_svalid%0d", j), 64'(send_cmd_valid), 64'd1);
         check_val($sformatf("bp_schunk%0d", j), 64'(send_cmd_chunk), 64'd1);
         check_val($sformatf("bp_saddr%0d", j), send_cmd_addr, 64'h1_0000_1000);
         check_val($sformatf("bp_slen%0d", j), 64'(send_cmd_len), 64'h1000);
         check_val($sformatf("bp_step%0d", j), 64'(step), 64'd0);
         if (j >= 1) check_val($sformatf("bp_rvalid%0d", j), 64'(recv_cmd_valid), 64'd0);
         @(negedge clk);
      end
      send_cmd_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_val("bp_step_hold", 64'(step), 64'd0);
      check_val("bp_svalid_low", 64'(send_cmd_valid), 64'd0);
      for (int i = 0; i < 20; i++) begin
         if (send_cmd_valid) break;
         @(negedge clk);
      end
      check_val("bp_step1", 64'(step), 64'd1);
      check_val("bp_schunk1", 64'(send_cmd_chunk), 64'd0);
      wait_done("bp");

      // Manual done pulses: simultaneous pair, then a stray recv_done in NEXT
      auto_en = 1'b0;
      clear_mon();
      set_cfg(32'd1, 32'd4);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check_val("sim_valid0", 64'(send_cmd_valid & recv_cmd_valid), 64'd1);
      @(negedge clk);
      man_send_done = 1'b1; man_recv_done = 1'b1;
      @(negedge clk);
      man_send_done = 1'b0; man_recv_done = 1'b1;
      @(negedge clk);
      man_recv_done = 1'b0;
      check_val("sim_step1", 64'(step), 64'd1);
      check_val("sim_valid1", 64'(send_cmd_valid), 64'd1);
      @(negedge clk);
      man_send_done = 1'b1;
      @(negedge clk);
      man_send_done = 1'b0;
      repeat (2) @(negedge clk);
      check_val("stray_step", 64'(step), 64'd1);
      check_val("stray_svalid", 64'(send_cmd_valid), 64'd0);
      check_val("stray_busy", 64'(busy), 64'd1);
      man_recv_done = 1'b1;
      @(negedge clk);
      man_recv_done = 1'b0;
      @(negedge clk);
      check_val("sim_step2", 64'(step), 64'd2);
      check_val("sim_schunk2", 64'(send_cmd_chunk), 64'd3);
      check_val("sim_rchunk2", 64'(recv_cmd_chunk), 64'd2);
      @(negedge clk);
      check_val("wait2_svalid", 64'(send_cmd_valid), 64'd0);
      check_val("wait2_busy", 64'(busy), 64'd1);

      // Asynchronous reset in WAIT of step 2
      #3 rstn = 1'b0;
      #1 check_all_zero("async_rst");
      @(negedge clk);
      rstn = 1'b1;
      auto_en = 1'b1;
      clear_mon();
      repeat (5) @(negedge clk);
      check_val("post_rst_valids", 64'(valid_cnt), 64'd0);
      check_val("post_rst_busy", 64'(busy), 64'd0);
      run_full(1'b0, "rerun");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mpi_ring_scheduler.md
MPI_RING_SCHEDULER -- requirements
Module: mpi_ring_scheduler

Interface
REQ-001 SHALL have parameter: MAX_CLIENT, 8, maximum ring size; the legal client_num range is 2..MAX_CLIENT.
REQ-002 SHALL have port: clk  in  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port: rstn  in  1  reset; asynchronous assert, active-low.
REQ-004 SHALL have port: start  in  1  single-cycle run request.
REQ-005 SHALL have ports: client_id / client_num / client_length  in  32 each  own rank / ring size / chunk bytes.
REQ-006 SHALL have port: base_addr  in  64  memory base of the reduce buffer.
REQ-007 SHALL have ports: send_cmd_valid out 1, send_cmd_ready in 1, send_cmd_chunk out 8, send_cmd_addr out 64, send_cmd_len out 32  tx chunk command.
REQ-008 SHALL have ports: recv_cmd_valid out 1, recv_cmd_ready in 1, recv_cmd_chunk out 8, recv_cmd_addr out 64, recv_cmd_reduce out 1  rx chunk command (1 = add into buffer, 0 = overwrite).
REQ-009 SHALL have ports: send_done in 1, recv_done in 1  single-cycle completion pulses from the tx and rx datapaths.
REQ-010 SHALL have ports: busy out 1, done out 1 (pulse), error out 1, phase out 1 (0 = reduce-scatter, 1 = all-gather), step out 8.

Function
REQ-011 SHALL implement states IDLE, CHECK, ISSUE, WAIT, NEXT, FINISH.
REQ-012 SHALL latch all config inputs when start=1 in IDLE; start in any other state SHALL be ignored.
REQ-013 CHECK SHALL flag an invalid config when any of these holds: client_num<2, client_num>MAX_CLIENT, client_id>=client_num, or client_length==0.
REQ-014 On an invalid config, SHALL set error=1, pulse done for 1 cycle, issue no command, and return to IDLE.
REQ-015 On a valid config, SHALL enter ISSUE with step=0, phase=0, send chunk=client_id.
REQ-016 First send_cmd_valid/recv_cmd_valid SHALL rise 2 cycles after the start cycle.
REQ-017 Each run SHALL have 2*(client_num-1) total steps.
REQ-018 phase SHALL be 0 for steps 0..N-2 and 1 for steps N-1..2N-3; step SHALL count within the phase, resetting to 0 at the phase change.
REQ-019 Send chunk SHALL decrement mod N every step (0 wraps to N-1).
REQ-020 Recv chunk SHALL always equal (send chunk - 1) mod N.
REQ-021 recv_cmd_reduce SHALL equal ~phase.
REQ-022 Addresses SHALL be computed as base_addr + chunk*client_length, truncated to 64 bits; send_cmd_len SHALL equal client_length.
REQ-023 In ISSUE both valids SHALL assert together; each SHALL hold, with stable payload, until its own ready, then deassert independently.
REQ-024 The FSM SHALL move ISSUE->WAIT once both commands are accepted.
REQ-025 A send_done (recv_done) pulse SHALL set its step flag only if the matching command has already been accepted this step; otherwise the pulse SHALL be ignored.
REQ-026 A done pulse arriving in the same cycle as its command's acceptance SHALL count.
REQ-027 Simultaneous send_done and recv_done SHALL both count.
REQ-028 When both flags are set, the FSM SHALL enter NEXT (1 cycle: clear flags, advance counters), then ISSUE, or FINISH after the last step.
REQ-029 FINISH SHALL pulse done=1 for 1 cycle with error=0, then return to IDLE.
REQ-030 busy SHALL be 1 in every state except IDLE.
REQ-031 error SHALL hold until the next accepted start.

Reset
REQ-032 While rstn=0, SHALL force state IDLE and all outputs, counters and flags to 0, including mid-run with commands pending.
REQ-033 After rstn deasserts, SHALL issue no command until a new start.

Verification
REQ-034 SHALL cover N=4, id=1, len=0x1000, base=0x1_0000_0000, ready=1, done returned 3 cycles after each accept -> 6 steps:
- send chunks 1,0,3,2,1,0;
- recv chunks 0,3,2,1,0,3;
- reduce=1,1,1,0,0,0;
- first send_cmd_addr=0x1_0000_1000;
- one done pulse, error=0.
REQ-035 SHALL cover client_num=1, then separately client_id=5 with client_num=4 -> no valid asserted, error=1, single done pulse, busy high exactly 2 cycles.
REQ-036 SHALL cover send_cmd_ready held 0 for 5 cycles while recv accepted -> send payload stable throughout; recv_cmd_valid drops after 1 cycle; step does not advance until send accepted and both dones seen.
REQ-037 SHALL cover send_done and recv_done in the same cycle, plus a stray recv_done in NEXT -> step advances exactly once; stray pulse ignored.
REQ-038 SHALL cover a second start mid-run -> ignored, sequence unchanged.
REQ-039 SHALL cover rstn=0 during WAIT of step 2 -> all outputs 0 asynchronously; after release, a new start reruns from step 0.
